// File: rtl/buf_loader.sv
// Command FIFO producer: streams a contiguous block of 40-bit entries from a
// synchronous command RAM into the executor FIFO, honouring fifo_full.
module buf_loader #(
   parameter int unsigned ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd,
   input  logic [63:0]           mem_data,
   input  logic                  fifo_full,
   output logic                  fifo_write,
   output logic [39:0]           fifo_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic                  bad_entry,
   output logic [31:0]           words_written
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH:0]   rem_q, rem_d;
   logic                  infl_q, infl_d;
   logic [39:0]           hold_q, hold_d;
   logic                  hold_vld_q, hold_vld_d;
   logic                  done_q, done_d;
   logic                  aborted_q, aborted_d;
   logic                  bad_q, bad_d;
   logic [31:0]           words_q, words_d;
   logic                  ret_bad;
   logic                  wr_int;
   logic                  rd_int;
   logic [39:0]           wdata_int;
   logic                  unused_bits;

   assign unused_bits = ^mem_data[62:40];
   assign ret_bad     = infl_q & ~mem_data[63];

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      rem_d      = rem_q;
      infl_d     = infl_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      done_d     = done_q;
      aborted_d  = aborted_q;
      bad_d      = bad_q;
      words_d    = words_q;
      wr_int     = 1'b0;
      rd_int     = 1'b0;
      wdata_int  = '0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               ptr_d      = start_addr;
               rem_d      = length;
               done_d     = (length == '0);
               aborted_d  = 1'b0;
               bad_d      = 1'b0;
               words_d    = '0;
               infl_d     = 1'b0;
               hold_vld_d = 1'b0;
               if (length != '0) state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d    = S_IDLE;
               aborted_d  = 1'b1;
               infl_d     = 1'b0;
               hold_vld_d = 1'b0;
            end else if (ret_bad) begin
               state_d    = S_IDLE;
               bad_d      = 1'b1;
               infl_d     = 1'b0;
               hold_vld_d = 1'b0;
            end else begin
               infl_d = 1'b0;
               // An entry in flight and an occupied hold never coexist, so
               // the return path and the drain path are mutually exclusive.
               if (infl_q) begin
                  if (!fifo_full) begin
                     wr_int    = 1'b1;
                     wdata_int = mem_data[39:0];
                  end else begin
                     hold_d     = mem_data[39:0];
                     hold_vld_d = 1'b1;
                  end
               end else if (hold_vld_q && !fifo_full) begin
                  wr_int     = 1'b1;
                  wdata_int  = hold_q;
                  hold_vld_d = 1'b0;
               end
               if ((rem_q != '0) && !hold_vld_q && !fifo_full) begin
                  rd_int = 1'b1;
                  ptr_d  = ptr_q + ADDR_WIDTH'(1);
                  rem_d  = rem_q - (ADDR_WIDTH + 1)'(1);
                  infl_d = 1'b1;
               end
               words_d = words_q + 32'(wr_int);
               if ((rem_d == '0) && !infl_d && !hold_vld_d) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         rem_q      <= '0;
         infl_q     <= 1'b0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
         bad_q      <= 1'b0;
         words_q    <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rem_q      <= rem_d;
         infl_q     <= infl_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         done_q     <= done_d;
         aborted_q  <= aborted_d;
         bad_q      <= bad_d;
         words_q    <= words_d;
      end
   end

   assign mem_rd        = rd_int & ~rst;
   assign mem_addr      = rst ? '0 : ptr_q;
   assign fifo_write    = wr_int & ~rst;
   assign fifo_wdata    = rst ? '0 : wdata_int;
   assign busy          = (state_q == S_RUN);
   assign done          = done_q;
   assign aborted       = aborted_q;
   assign bad_entry     = bad_q;
   assign words_written = words_q;

endmodule
